// File: rtl/core_output_ctrl.sv
// Deskews PE-array column results into aligned vectors and queues them in a DEPTH-entry FIFO; COLS-1 cycles skew-to-write, dvalid the cycle after a push.
// Backpressure via dvalid/dready; a vector arriving while full with no pop is dropped and flagged on sticky ovf. Requires COLS >= 2.
module core_output_ctrl #(
    parameter int COLS     = 8,
    parameter int OUTWIDTH = 32,
    parameter int DEPTH    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [OUTWIDTH-1:0]       psum_in [0:COLS-1],
    input  logic                      psum_vld,
    input  logic                      clr,
    output logic [OUTWIDTH-1:0]       dout [0:COLS-1],
    output logic                      dvalid,
    input  logic                      dready,
    output logic                      full,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [COLS-2:0]      r_vld_pipe;
    logic [OUTWIDTH-1:0]  w_aligned [0:COLS-1];
    logic [OUTWIDTH-1:0]  r_mem [0:DEPTH-1][0:COLS-1];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [LW-1:0]        r_level;
    logic                 r_ovf;
    logic                 w_wr_en;
    logic                 w_pop;
    logic                 w_push;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_pipe <= '0;
        end else if (clr) begin
            r_vld_pipe <= '0;
        end else begin
            r_vld_pipe[0] <= psum_vld;
            for (int k = 1; k < COLS - 1; k++)
                r_vld_pipe[k] <= r_vld_pipe[k-1];
        end
    end

    // Lane j arrives j cycles late, so it needs COLS-1-j stages to line up with the last lane.
    for (genvar j = 0; j < COLS - 1; j++) begin : g_lane
        localparam int N = COLS - 1 - j;
        logic [OUTWIDTH-1:0] r_sr [0:N-1];
        always_ff @(posedge clk) begin
            r_sr[0] <= psum_in[j];
            for (int k = 1; k < N; k++)
                r_sr[k] <= r_sr[k-1];
        end
        assign w_aligned[j] = r_sr[N-1];
    end
    assign w_aligned[COLS-1] = psum_in[COLS-1];

    assign w_wr_en = r_vld_pipe[COLS-2];
    assign dvalid  = (r_level != '0);
    assign full    = (r_level == LW'(DEPTH));
    assign w_pop   = dvalid && dready;
    assign w_push  = w_wr_en && (!full || w_pop);
    assign level   = r_level;
    assign ovf     = r_ovf;

    always_ff @(posedge clk) begin
        if (w_push) begin
            for (int c = 0; c < COLS; c++)
                r_mem[r_wr_ptr][c] <= w_aligned[c];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ovf    <= 1'b0;
        end else if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)
                r_level <= r_level + LW'(1);
            else if (!w_push && w_pop)
                r_level <= r_level - LW'(1);
            if (w_wr_en && !w_push)
                r_ovf <= 1'b1;
        end
    end

    // Gating on dvalid keeps dout at zero when empty, including during reset.
    always_comb begin
        for (int c = 0; c < COLS; c++)
            dout[c] = dvalid ? r_mem[r_rd_ptr][c] : '0;
    end
endmodule

// File: tb/tb_core_output_ctrl.sv
// Bench for core_output_ctrl: directed scenarios plus random traffic against a queue-based reference model.
module tb_core_output_ctrl;
    localparam int COLS  = 4;
    localparam int W     = 32;
    localparam int DEPTH = 4;
    localparam int MAXC  = 4096;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  psum_in [0:COLS-1];
    logic          psum_vld;
    logic          clr;
    logic [W-1:0]  dout [0:COLS-1];
    logic          dvalid;
    logic          dready;
    logic          full;
    logic [2:0]    level;
    logic          ovf;

    core_output_ctrl #(.COLS(COLS), .OUTWIDTH(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .psum_in(psum_in), .psum_vld(psum_vld), .clr(clr),
        .dout(dout), .dvalid(dvalid), .dready(dready), .full(full), .level(level), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    logic          hist_vld [MAXC];
    logic          hist_clr [MAXC];
    logic [W-1:0]  hist_dat [MAXC][COLS];
    logic [127:0]  mq [$];
    logic          m_ovf;
    logic          s_dvalid, s_full, s_ovf;
    logic [2:0]    s_level;
    logic [127:0]  s_dout;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic record();
        hist_vld[cyc] = psum_vld;
        hist_clr[cyc] = clr;
        for (int j = 0; j < COLS; j++) hist_dat[cyc][j] = psum_in[j];
    endtask

    task automatic sample();
        s_dvalid = dvalid;
        s_full   = full;
        s_ovf    = ovf;
        s_level  = level;
        for (int j = 0; j < COLS; j++) s_dout[j*W +: W] = dout[j];
    endtask

    task automatic compare_model();
        int n = mq.size();
        check("dvalid", {127'd0, s_dvalid}, {127'd0, n != 0});
        check("level",  {125'd0, s_level}, 128'(n));
        check("full",   {127'd0, s_full}, {127'd0, n == DEPTH});
        check("ovf",    {127'd0, s_ovf}, {127'd0, m_ovf});
        check("dout",   s_dout, (n != 0) ? mq[0] : 128'd0);
    endtask

    // Vector launched at cycle t reaches the FIFO write port at t+COLS-1 unless a clr lands in between.
    task automatic model_step();
        int n = mq.size();
        bit wr = 0;
        bit pop;
        logic [127:0] v = '0;
        if (cyc >= COLS - 1 && hist_vld[cyc-(COLS-1)]) begin
            wr = 1;
            for (int k = cyc - (COLS - 1); k <= cyc; k++) if (hist_clr[k]) wr = 0;
        end
        if (hist_clr[cyc]) begin
            mq.delete();
            m_ovf = 0;
        end else begin
            pop = (n != 0) && dready;
            if (wr)
                for (int j = 0; j < COLS; j++) v[j*W +: W] = hist_dat[cyc-(COLS-1)+j][j];
            if (pop) void'(mq.pop_front());
            if (wr) begin
                if (n < DEPTH || pop) mq.push_back(v);
                else m_ovf = 1;
            end
        end
    endtask

    task automatic half_a();
        record();
        @(negedge clk);
        sample();
        compare_model();
    endtask

    task automatic half_b();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
    endtask

    task automatic cycle();
        half_a();
        half_b();
    endtask

    task automatic drive(input bit vld, input bit rdy, input bit cl);
        psum_vld = vld;
        dready   = rdy;
        clr      = cl;
        for (int j = 0; j < COLS; j++) psum_in[j] = $urandom;
    endtask

    int  npop;
    int  maxlvl;
    bit  seen;

    initial begin
        rst = 1'b1;
        m_ovf = 0;
        drive(0, 0, 0);
        for (int j = 0; j < COLS; j++) psum_in[j] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        sample();
        check("rst_dvalid", {127'd0, s_dvalid}, 128'd0);
        check("rst_level",  {125'd0, s_level}, 128'd0);
        check("rst_full",   {127'd0, s_full}, 128'd0);
        check("rst_ovf",    {127'd0, s_ovf}, 128'd0);
        check("rst_dout",   s_dout, 128'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc = 0;

        // Single aligned vector, launch at cycle 10.
        while (cyc < 10) begin drive(0, 0, 0); cycle(); end
        for (int k = 0; k < 5; k++) begin
            drive(k == 0, 0, 0);
            for (int j = 0; j < COLS; j++) if (k == j) psum_in[j] = 32'h10 + j;
            cycle();
            if (k == 3) check("c13_dvalid", {127'd0, s_dvalid}, 128'd0);
            if (k == 4) begin
                check("c14_dvalid", {127'd0, s_dvalid}, 128'd1);
                check("c14_dout", s_dout, 128'h00000013_00000012_00000011_00000010);
                check("c14_level", {125'd0, s_level}, 128'd1);
            end
        end
        drive(0, 1, 0); cycle();
        drive(0, 0, 0); cycle();
        check("drain1_empty", {127'd0, s_dvalid}, 128'd0);

        // Overflow: five back-to-back with no consumer.
        for (int k = 0; k < 5; k++) begin drive(1, 0, 0); cycle(); end
        for (int k = 0; k < 4; k++) begin drive(0, 0, 0); cycle(); end
        check("ovf5_level", {125'd0, s_level}, 128'd4);
        check("ovf5_full",  {127'd0, s_full}, 128'd1);
        check("ovf5_ovf",   {127'd0, s_ovf}, 128'd1);
        npop = 0;
        for (int k = 0; k < 6; k++) begin
            drive(0, 1, 0); cycle();
            if (s_dvalid) npop++;
        end
        check("ovf5_pops", 128'(npop), 128'd4);
        check("ovf5_empty", {127'd0, s_dvalid}, 128'd0);
        check("ovf5_sticky", {127'd0, s_ovf}, 128'd1);

        // Full FIFO with a simultaneous push and pop.
        drive(0, 0, 1); cycle();
        drive(0, 0, 0); cycle();
        check("clr_ovf",   {127'd0, s_ovf}, 128'd0);
        check("clr_level", {125'd0, s_level}, 128'd0);
        for (int k = 0; k < 4; k++) begin drive(1, 0, 0); cycle(); end
        for (int k = 0; k < 4; k++) begin drive(0, 0, 0); cycle(); end
        drive(1, 0, 0); cycle();
        drive(0, 0, 0); cycle();
        drive(0, 0, 0); cycle();
        drive(0, 1, 0); cycle();
        check("fp_pre_full", {127'd0, s_full}, 128'd1);
        drive(0, 0, 0); cycle();
        check("fp_level", {125'd0, s_level}, 128'd4);
        check("fp_ovf",   {127'd0, s_ovf}, 128'd0);

        // Pointer wrap: ten vectors streamed with the consumer always ready.
        drive(0, 0, 1); cycle();
        npop = 0; maxlvl = 0;
        for (int k = 0; k < 14; k++) begin
            drive(k < 10, 1, 0); cycle();
            if (s_dvalid) npop++;
            if (int'(s_level) > maxlvl) maxlvl = int'(s_level);
        end
        check("wrap_pops", 128'(npop), 128'd10);
        check("wrap_maxlvl_le1", {127'd0, maxlvl <= 1}, 128'd1);
        check("wrap_ovf", {127'd0, s_ovf}, 128'd0);

        // clr two cycles after launch discards the in-flight vector.
        drive(1, 0, 0); cycle();
        drive(0, 0, 0); cycle();
        drive(0, 0, 1); cycle();
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0); cycle();
            if (s_dvalid) seen = 1;
        end
        check("clrfl_seen",  {127'd0, seen}, 128'd0);
        check("clrfl_level", {125'd0, s_level}, 128'd0);
        check("clrfl_ovf",   {127'd0, s_ovf}, 128'd0);

        // Random traffic: low then high consumer readiness.
        for (int k = 0; k < 400; k++) begin
            drive(1'($urandom_range(0, 1)),
                  (k < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 39) == 0);
            cycle();
        end

        // Asynchronous reset with level=3 and ovf=1.
        drive(0, 0, 1); cycle();
        for (int k = 0; k < 5; k++) begin drive(1, 0, 0); cycle(); end
        for (int k = 0; k < 4; k++) begin drive(0, 0, 0); cycle(); end
        drive(0, 1, 0); cycle();
        drive(0, 0, 0);
        half_a();
        check("pre_rst_level", {125'd0, s_level}, 128'd3);
        check("pre_rst_ovf",   {127'd0, s_ovf}, 128'd1);
        rst = 1'b1;
        #1;
        sample();
        check("arst_dvalid", {127'd0, s_dvalid}, 128'd0);
        check("arst_level",  {125'd0, s_level}, 128'd0);
        check("arst_full",   {127'd0, s_full}, 128'd0);
        check("arst_ovf",    {127'd0, s_ovf}, 128'd0);
        check("arst_dout",   s_dout, 128'd0);
        mq.delete();
        m_ovf = 0;
        for (int k = 0; k < cyc; k++) hist_vld[k] = 0;
        psum_vld = 1'b1;
        for (int j = 0; j < COLS; j++) psum_in[j] = $urandom;
        #1;
        rst = 1'b0;
        record();
        half_b();
        for (int k = 0; k < 4; k++) begin drive(0, 0, 0); cycle(); end
        check("post_rst_first", {125'd0, s_level}, 128'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
